// File: rtl/arm_core_sequencer_pkg.sv
// Shared encodings and helpers for the multi-cycle ARM control sequencer.
package arm_core_sequencer_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  localparam int unsigned WORD_INC = 4;

  // CPSR flag positions shared with the datapath.
  localparam int unsigned N_BIT = 31;
  localparam int unsigned Z_BIT = 30;
  localparam int unsigned C_BIT = 29;
  localparam int unsigned V_BIT = 28;

  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/arm_core_sequencer_if.sv
// Instruction- and data-memory req/ack buses driven by the sequencer.
interface arm_core_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              inst_req;
  logic [ADDR_W-3:0] inst_addr;
  logic              inst_ack;
  logic [31:0]       inst_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_ack, inst_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_ack, inst_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/arm_wait_timer.sv
// Wait-state counter shared by the fetch and data-memory phases.
module arm_wait_timer
  import arm_core_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int unsigned CW = cnt_width(TIMEOUT);

  logic [CW-1:0] count_q, count_d;

  // TIMEOUT of zero never expires; the counter is then free to wrap.
  assign expired_o = (TIMEOUT != 0) && (count_q == CW'(TIMEOUT));

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !expired_o) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/arm_core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with req/ack memories,
// wait-state timeout, misalignment fault and sticky halt.
module arm_core_sequencer
  import arm_core_sequencer_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  arm_core_sequencer_if.master bus,
  output logic [31:0]          inst_reg,
  input  logic                 dec_cond_pass,
  input  logic                 dec_is_load,
  input  logic                 dec_is_store,
  input  logic                 dec_is_branch,
  input  logic                 dec_wb_rd,
  input  logic                 dec_set_flags,
  input  logic                 dec_halt,
  input  logic [31:0]          alu_out,
  input  logic [ADDR_W-1:0]    branch_target,
  input  logic [31:0]          store_data,
  output logic [31:0]          wb_data,
  output logic                 rd_we,
  output logic                 cpsr_we,
  output logic                 pc_we,
  output logic [ADDR_W-1:0]    pc_out,
  output logic                 halted,
  output logic                 fault
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       inst_reg_q, inst_reg_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              halted_q, halted_d;
  logic              fault_q, fault_d;

  logic              expired;
  logic              inst_fire, mem_fire;
  logic [ADDR_W-1:0] pc_inc;

  // inst_req is gated by rst so the request vanishes the moment reset asserts,
  // even though the reset state itself is FETCH.
  assign bus.inst_req  = (state_q == ST_FETCH) && !expired && !rst;
  assign bus.inst_addr = pc_q[ADDR_W-1:2];
  assign bus.mem_req   = (state_q == ST_MEM) && !expired;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign inst_fire = bus.inst_req && bus.inst_ack;
  assign mem_fire  = bus.mem_req && bus.mem_ack;
  assign pc_inc    = pc_q + ADDR_W'(WORD_INC);

  assign inst_reg = inst_reg_q;
  assign wb_data  = wb_data_q;
  assign pc_out   = pc_q;
  assign halted   = halted_q;
  assign fault    = fault_q;

  arm_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .inc_i     ((bus.inst_req && !bus.inst_ack) || (bus.mem_req && !bus.mem_ack)),
    .clr_i     (inst_fire || mem_fire || (state_d != state_q)),
    .expired_o (expired)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_reg_d  = inst_reg_q;
    wb_data_d   = wb_data_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    halted_d    = halted_q;
    fault_d     = fault_q;
    rd_we       = 1'b0;
    cpsr_we     = 1'b0;
    pc_we       = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (expired) begin
          fault_d  = 1'b1;
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else if (inst_fire) begin
          inst_reg_d = bus.inst_rdata;
          state_d    = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (!dec_cond_pass) begin
          pc_d    = pc_inc;
          pc_we   = 1'b1;
          state_d = ST_FETCH;
        end else if (dec_halt) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else if (dec_is_load || dec_is_store) begin
          if (alu_out[1:0] != 2'b00) begin
            fault_d  = 1'b1;
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end else begin
            mem_addr_d  = alu_out[ADDR_W-1:2];
            mem_we_d    = dec_is_store;
            mem_wdata_d = store_data;
            state_d     = ST_MEM;
          end
        end else begin
          // Non-memory result is captured here; alu_out is stable through WB anyway.
          wb_data_d = alu_out;
          state_d   = ST_WB;
        end
      end
      ST_MEM: begin
        if (expired) begin
          fault_d  = 1'b1;
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else if (mem_fire) begin
          if (mem_we_q) begin
            pc_d    = pc_inc;
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            wb_data_d = bus.mem_rdata;
            state_d   = ST_WB;
          end
        end
      end
      ST_WB: begin
        rd_we   = dec_wb_rd;
        cpsr_we = dec_set_flags && !dec_is_load;
        pc_we   = 1'b1;
        pc_d    = dec_is_branch ? (branch_target & ~ADDR_W'(2'b11)) : pc_inc;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      inst_reg_q  <= '0;
      wb_data_q   <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_reg_q  <= inst_reg_d;
      wb_data_q   <= wb_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      halted_q    <= halted_d;
      fault_q     <= fault_d;
    end
  end

endmodule

// File: tb/tb_arm_core_sequencer.sv
// Scoreboard bench: stimulus queues expected fetches, data accesses and retirements;
// a negedge monitor pops and compares them as the sequencer presents each one.
module tb_arm_core_sequencer;

  typedef struct {
    logic        rd;
    logic        cpsr;
    logic [31:0] wb;
    int unsigned lat;
  } retire_t;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
  } memx_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dec_cond_pass, dec_is_load, dec_is_store, dec_is_branch;
  logic        dec_wb_rd, dec_set_flags, dec_halt;
  logic [31:0] alu_out, store_data;
  logic [31:0] branch_target;
  logic [31:0] inst_reg, wb_data;
  logic        rd_we, cpsr_we, pc_we, halted, fault;
  logic [31:0] pc_out;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  retire_t     ret_q[$];
  memx_t       mem_q[$];
  logic [29:0] fetch_q[$];

  int unsigned cyc = 0;
  int unsigned fetch_cyc = 0;
  int unsigned mem_req_cnt = 0;
  int unsigned mem_wait = 0;
  int unsigned mcnt = 0;
  logic        prev_mem_req = 1'b0;
  memx_t       cur_mem, m;
  retire_t     r;
  logic [29:0] fa;

  always #5 clk = ~clk;

  arm_core_sequencer_if #(.ADDR_W(32)) bus ();

  arm_core_sequencer #(
    .ADDR_W   (32),
    .RESET_PC (32'h0),
    .TIMEOUT  (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .inst_reg      (inst_reg),
    .dec_cond_pass (dec_cond_pass),
    .dec_is_load   (dec_is_load),
    .dec_is_store  (dec_is_store),
    .dec_is_branch (dec_is_branch),
    .dec_wb_rd     (dec_wb_rd),
    .dec_set_flags (dec_set_flags),
    .dec_halt      (dec_halt),
    .alu_out       (alu_out),
    .branch_target (branch_target),
    .store_data    (store_data),
    .wb_data       (wb_data),
    .rd_we         (rd_we),
    .cpsr_we       (cpsr_we),
    .pc_we         (pc_we),
    .pc_out        (pc_out),
    .halted        (halted),
    .fault         (fault)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Data memory: ack after mem_wait idle request cycles.
  always @(posedge clk) begin
    #1;
    if (bus.mem_req && !rst) begin
      if (mcnt == mem_wait) begin
        bus.mem_ack = 1'b1;
        mcnt = 0;
      end else begin
        bus.mem_ack = 1'b0;
        mcnt++;
      end
    end else begin
      bus.mem_ack = 1'b0;
      mcnt = 0;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_mem_req = 1'b0;
    end else begin
      if (bus.inst_req && bus.inst_ack) begin
        fetch_cyc = cyc;
        if (fetch_q.size() == 0) check("fetch_unexpected", 64'(fetch_q.size()), 64'd1);
        else begin
          fa = fetch_q.pop_front();
          check("inst_addr", 64'(bus.inst_addr), 64'(fa));
        end
      end
      if (bus.mem_req) begin
        mem_req_cnt++;
        if (!prev_mem_req) begin
          if (mem_q.size() == 0) check("mem_unexpected", 64'(mem_q.size()), 64'd1);
          else begin
            m = mem_q.pop_front();
            check("mem_addr", 64'(bus.mem_addr), 64'(m.addr));
            check("mem_we", 64'(bus.mem_we), 64'(m.we));
            if (m.we) check("mem_wdata", 64'(bus.mem_wdata), 64'(m.wdata));
          end
          cur_mem.we    = bus.mem_we;
          cur_mem.addr  = bus.mem_addr;
          cur_mem.wdata = bus.mem_wdata;
        end else begin
          check("mem_hold", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
                {cur_mem.we, cur_mem.addr, cur_mem.wdata});
        end
      end
      prev_mem_req = bus.mem_req;
      if (rd_we || cpsr_we) check("strobe_without_pc_we", 64'(pc_we), 64'd1);
      if (pc_we) begin
        if (ret_q.size() == 0) check("retire_unexpected", 64'(ret_q.size()), 64'd1);
        else begin
          r = ret_q.pop_front();
          check("rd_we", 64'(rd_we), 64'(r.rd));
          check("cpsr_we", 64'(cpsr_we), 64'(r.cpsr));
          if (r.rd) check("wb_data", 64'(wb_data), 64'(r.wb));
          check("latency", 64'(cyc - fetch_cyc + 1), 64'(r.lat));
        end
      end
    end
  end

  task automatic set_dec(input logic c, input logic ld, input logic st, input logic br,
                         input logic wb, input logic sf, input logic h);
    dec_cond_pass = c;  dec_is_load   = ld; dec_is_store = st; dec_is_branch = br;
    dec_wb_rd     = wb; dec_set_flags = sf; dec_halt     = h;
  endtask

  task automatic push_ret(input logic rd, input logic cpsr, input logic [31:0] wb,
                          input int unsigned lat);
    retire_t e;
    e.rd = rd; e.cpsr = cpsr; e.wb = wb; e.lat = lat;
    ret_q.push_back(e);
  endtask

  task automatic push_mem(input logic we, input logic [29:0] addr, input logic [31:0] wd);
    memx_t e;
    e.we = we; e.addr = addr; e.wdata = wd;
    mem_q.push_back(e);
  endtask

  // Asserts reset, checks the reset state, releases it just after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_inst_req", 64'(bus.inst_req), 64'd0);
    check("rst_mem_req", 64'(bus.mem_req), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_pc", 64'(pc_out), 64'h0);
    check("rst_inst_reg", 64'(inst_reg), 64'h0);
    check("rst_strobes", {rd_we, cpsr_we, pc_we}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_pc_we(input int unsigned bound);
    bit ok = 0;
    for (int unsigned i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (pc_we) ok = 1;
    end
    check("wait_pc_we", 64'(ok), 64'd1);
  endtask

  task automatic settle_and_drain(input logic [31:0] exp_pc);
    @(posedge clk); #1;
    check("pc_after", 64'(pc_out), 64'(exp_pc));
    @(negedge clk);
    @(posedge clk); #1;
    check("queues_empty", 64'(ret_q.size() + mem_q.size() + fetch_q.size()), 64'd0);
  endtask

  initial begin
    int unsigned n;
    int unsigned snap;
    bit ok;
    set_dec(1, 0, 0, 0, 0, 0, 0);
    alu_out = '0; store_data = '0; branch_target = '0;
    bus.inst_ack = 1'b1; bus.inst_rdata = 32'hE081_2003;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;

    // ADD without S, zero-wait fetch
    set_dec(1, 0, 0, 0, 1, 0, 0); alu_out = 32'h1234_5678;
    fetch_q.push_back(30'h0); push_ret(1, 0, 32'h1234_5678, 4); fetch_q.push_back(30'h1);
    do_reset();
    wait_pc_we(20);
    @(posedge clk); #1;
    check("inst_reg", 64'(inst_reg), 64'hE081_2003);
    check("pc_add", 64'(pc_out), 64'h4);
    @(negedge clk);
    @(posedge clk); #1;
    check("queues_empty", 64'(ret_q.size() + mem_q.size() + fetch_q.size()), 64'd0);

    // LDR with three wait states; S bit must not write CPSR on loads
    set_dec(1, 1, 0, 0, 1, 1, 0); alu_out = 32'h100; mem_wait = 3;
    bus.mem_rdata = 32'hDEAD_BEEF; store_data = 32'h1111_1111;
    fetch_q.push_back(30'h0); push_mem(0, 30'h40, 32'h0);
    push_ret(1, 0, 32'hDEAD_BEEF, 8); fetch_q.push_back(30'h1);
    do_reset();
    wait_pc_we(30);
    settle_and_drain(32'h4);

    // Aligned STR, zero wait
    set_dec(1, 0, 1, 0, 0, 0, 0); alu_out = 32'h204; store_data = 32'hCAFE_F00D; mem_wait = 0;
    fetch_q.push_back(30'h0); push_mem(1, 30'h81, 32'hCAFE_F00D);
    push_ret(0, 0, 32'h0, 4); fetch_q.push_back(30'h1);
    do_reset();
    wait_pc_we(20);
    settle_and_drain(32'h4);

    // Misaligned STR faults without a data request
    set_dec(1, 0, 1, 0, 0, 0, 0); alu_out = 32'h102;
    fetch_q.push_back(30'h0);
    do_reset();
    snap = mem_req_cnt;
    ok = 0;
    for (int unsigned i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (halted) ok = 1;
    end
    check("misalign_halt_seen", 64'(ok), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("misalign_fault", 64'(fault), 64'd1);
    check("misalign_halted", 64'(halted), 64'd1);
    check("misalign_pc", 64'(pc_out), 64'h0);
    check("misalign_no_mem_req", 64'(mem_req_cnt - snap), 64'd0);
    check("halt_no_inst_req", 64'(bus.inst_req), 64'd0);
    check("queues_empty", 64'(ret_q.size() + mem_q.size() + fetch_q.size()), 64'd0);

    // Fetch timeout with TIMEOUT=8, then a late ack
    bus.inst_ack = 1'b0; bus.inst_rdata = 32'h1234_5678;
    set_dec(1, 0, 0, 0, 1, 0, 0);
    do_reset();
    n = 0;
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.inst_req) break;
      n++;
    end
    check("timeout_req_cycles", 64'(n), 64'd8);
    @(posedge clk); #1;
    check("timeout_fault", 64'(fault), 64'd1);
    check("timeout_halted", 64'(halted), 64'd1);
    bus.inst_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("late_ack_inst_req", 64'(bus.inst_req), 64'd0);
    check("late_ack_inst_reg", 64'(inst_reg), 64'h0);
    check("late_ack_pc", 64'(pc_out), 64'h0);
    bus.inst_rdata = 32'hEA00_0080;

    // Branch, condition failed: S and Rd write ignored
    set_dec(0, 0, 0, 1, 1, 1, 0); branch_target = 32'h203;
    fetch_q.push_back(30'h0); push_ret(0, 0, 32'h0, 3); fetch_q.push_back(30'h1);
    do_reset();
    wait_pc_we(20);
    settle_and_drain(32'h4);

    // Branch taken to an unaligned target
    set_dec(1, 0, 0, 1, 0, 0, 0);
    fetch_q.push_back(30'h0); push_ret(0, 0, 32'h0, 4); fetch_q.push_back(30'h80);
    do_reset();
    wait_pc_we(20);
    settle_and_drain(32'h200);

    // Reset asserted mid data-access wait
    set_dec(1, 0, 0, 0, 1, 0, 0); alu_out = 32'h100; mem_wait = 6;
    fetch_q.push_back(30'h0); push_ret(1, 0, 32'h100, 4); fetch_q.push_back(30'h1);
    push_mem(0, 30'h40, 32'h0);
    do_reset();
    wait_pc_we(20);
    @(posedge clk); #1;
    set_dec(1, 1, 0, 0, 1, 0, 0);
    ok = 0;
    for (int unsigned i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.mem_req) ok = 1;
    end
    check("mem_req_seen", 64'(ok), 64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_mem_req", 64'(bus.mem_req), 64'd0);
    check("async_inst_req", 64'(bus.inst_req), 64'd0);
    check("async_pc", 64'(pc_out), 64'h0);
    check("async_strobes", {rd_we, cpsr_we, pc_we}, 64'd0);
    check("queues_empty", 64'(ret_q.size() + mem_q.size() + fetch_q.size()), 64'd0);
    fetch_q.push_back(30'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("restart_inst_req", 64'(bus.inst_req), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    check("queues_empty", 64'(ret_q.size() + mem_q.size() + fetch_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
